// File: rtl/pps_period_ctrl.sv
// PPS period controller: arms on enable, counts clk cycles between
// consecutive PPS edges and hands each period over a valid/ready port.
module pps_period_ctrl #(
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 60000000,
  parameter int          LOCK_N  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overrun,
  output logic             lost,
  input  logic             clear_status,
  output logic             locked,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_N);

  state_t           st_q;
  state_t           st_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       lock_q;
  logic [3:0]       lock_d;
  logic             capture;
  logic             timeout;
  logic             handshake;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    capture = 1'b0;
    timeout = 1'b0;
    if (!enable) begin
      st_d   = IDLE;
      cnt_d  = '0;
      lock_d = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          cnt_d = '0;
          st_d  = ARM;
        end
        ARM: begin
          if (edge_pulse) begin
            st_d  = MEASURE;
            cnt_d = CNT_ONE;
          end
        end
        MEASURE: begin
          // An edge landing on the timeout cycle still counts as a capture.
          if (edge_pulse) begin
            capture = 1'b1;
            cnt_d   = CNT_ONE;
            if (lock_q != LOCK_MAX) begin
              lock_d = lock_q + 4'd1;
            end
          end else if (cnt_q == TMO) begin
            timeout = 1'b1;
            st_d    = LOST;
            lock_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        LOST: begin
          if (edge_pulse) begin
            st_d  = MEASURE;
            cnt_d = CNT_ONE;
          end
        end
      endcase
    end
  end

  assign handshake = period_valid & period_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      lock_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      lost         <= 1'b0;
    end else begin
      if (capture) begin
        period       <= cnt_q;
        period_valid <= 1'b1;
      end else if (handshake) begin
        period_valid <= 1'b0;
      end
      // Set events beat a same-cycle clear.
      overrun <= (capture & period_valid & ~period_ready)
               | (overrun & ~clear_status);
      lost    <= timeout | (lost & ~clear_status);
    end
  end

  assign locked = (lock_q == LOCK_MAX);
  assign state  = st_q;

endmodule

// File: tb/tb_pps_period_ctrl.sv
// Randomized scoreboard bench for pps_period_ctrl with an
// edge-timestamp reference model.
module tb_pps_period_ctrl;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1200;
  localparam int LOCK_N  = 2;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic             edge_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             period_ready;
  logic             overrun;
  logic             lost;
  logic             clear_status;
  logic             locked;
  logic [1:0]       state;

  pps_period_ctrl #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .LOCK_N (LOCK_N)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .edge_pulse  (edge_pulse),
    .period      (period),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .overrun     (overrun),
    .lost        (lost),
    .clear_status(clear_status),
    .locked      (locked),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Periods the consumer should see, in order of acceptance.
  int exp_q[$];

  // Reference model: mode, edge timestamps and pending result.
  int m_mode  = 0;
  int cyc     = 0;
  int last_ed = 0;
  int m_caps  = 0;
  int m_per   = 0;
  bit m_valid = 0;
  bit m_ovr   = 0;
  bit m_lost  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && period_valid && period_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL handshake cycle %0d actual %0d expected none",
                 cyc, period);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(period) != e) begin
          errors++;
          $display("FAIL period_hs cycle %0d actual %0d expected %0d",
                   cyc, period, e);
        end
      end
    end
  end

  task automatic model(input bit en, input bit ep,
                       input bit rdy, input bit clr);
    bit cap;
    bit to;
    int per;
    cap = 0;
    to  = 0;
    per = 0;
    cyc++;
    if (!en) begin
      m_mode = 0;
      m_caps = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 || m_mode == 3) begin
      if (ep) begin
        m_mode  = 2;
        last_ed = cyc;
      end
    end else if (ep) begin
      cap     = 1;
      per     = cyc - last_ed;
      last_ed = cyc;
      if (m_caps < LOCK_N) m_caps++;
    end else if (cyc - last_ed == TIMEOUT) begin
      to     = 1;
      m_mode = 3;
      m_caps = 0;
    end
    m_ovr  = (cap && m_valid && !rdy) || (m_ovr && !clr);
    m_lost = to || (m_lost && !clr);
    if (cap) begin
      if (m_valid && !rdy) exp_q[exp_q.size()-1] = per;
      else exp_q.push_back(per);
      m_valid = 1;
      m_per   = per;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input bit en, input bit ep,
                      input bit rdy, input bit clr);
    @(posedge clk);
    #1;
    chk("state", int'(state), m_mode);
    chk("period_valid", int'(period_valid), int'(m_valid));
    chk("period", int'(period), m_per);
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("lost", int'(lost), int'(m_lost));
    chk("locked", int'(locked), int'(m_caps == LOCK_N));
    #1;
    enable       = en;
    edge_pulse   = ep;
    period_ready = rdy;
    clear_status = clr;
    model(en, ep, rdy, clr);
  endtask

  task automatic gap(input int n, input bit rdy, input bit clr);
    for (int i = 0; i < n - 1; i++) step(1, 0, rdy, 0);
    step(1, 1, rdy, clr);
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    edge_pulse   = 1'b0;
    period_ready = 1'b0;
    clear_status = 1'b0;
    repeat (5) begin
      @(negedge clk);
      edge_pulse = 1'($urandom_range(1));
      chk("rst_state", int'(state), 0);
      chk("rst_outs", int'({period_valid, overrun, lost, locked}), 0);
      chk("rst_period", int'(period), 0);
    end
    @(negedge clk);
    edge_pulse = 1'b0;
    reset_n    = 1'b1;

    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);

    // Steady 1000-cycle PPS, consumer always ready.
    for (int i = 0; i < 5; i++) gap(1000, 1, 0);
    // Consumer stalled across three 500-cycle periods.
    for (int i = 0; i < 3; i++) gap(500, 0, 0);
    repeat (3) step(1, 0, 1, 0);
    // Edge exactly at timeout, then real loss and recovery.
    gap(1197, 1, 0);
    gap(TIMEOUT, 1, 0);
    repeat (TIMEOUT + 10) step(1, 0, 1, 0);
    gap(7, 1, 0);
    gap(200, 1, 0);
    // Disable mid-measurement with an unread result.
    gap(300, 0, 0);
    repeat (20) step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    // Clear colliding with an overrun-setting capture.
    step(1, 0, 0, 0);
    gap(3, 0, 0);
    gap(100, 0, 0);
    gap(100, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);

    for (int i = 0; i < 30000; i++) begin
      step(($urandom_range(999) != 0),
           ($urandom_range(599) == 0),
           ($urandom_range(3) != 0),
           ($urandom_range(49) == 0));
    end

    repeat (4) step(0, 0, 1, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pps_period_ctrl.md
Name: pps_period_ctrl

Overview:
Controller that consumes the single-cycle rising-edge pulse from the PPS input synchronizer/edge detector and sequences period measurement of the PPS signal in clk cycles. It arms on enable, measures the cycle count between consecutive edges, and presents each result through a valid/ready handshake to the register/readout logic. It also tracks lock, lost-signal timeout and result overrun status.

Parameters:
CNT_W, 32, width of cycle counter and period result
TIMEOUT, 60000000, counter value in MEASURE at which the signal is declared lost; must satisfy 2 <= TIMEOUT < 2^CNT_W - 1
LOCK_N, 2, consecutive captured periods required before locked asserts (1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
enable  in  1  level; high runs the controller, low forces IDLE
edge_pulse  in  1  one-clk pulse per PPS rising edge, already synchronized to clk
period  out  CNT_W  captured clk cycles between consecutive edges
period_valid  out  1  period holds an unconsumed result
period_ready  in  1  consumer accepts period when high with period_valid
overrun  out  1  sticky: a result was overwritten before being consumed
lost  out  1  sticky: TIMEOUT expired with no edge
clear_status  in  1  one-cycle clear of overrun and lost
locked  out  1  LOCK_N consecutive periods captured without loss
state  out  2  current state encoding, for status readback

Behaviour:
- Reset: state=IDLE(0), counter=0, period=0, period_valid=0, overrun=0, lost=0, locked=0, lock count=0. All flops on async reset_n.
- States: IDLE=0, ARM=1, MEASURE=2, LOST=3.
- IDLE: counter held 0. enable=1 -> ARM next cycle.
- ARM: waiting for first edge, no counting. edge_pulse -> MEASURE, counter<=1, no capture.
- MEASURE: counter increments by 1 per cycle. On edge_pulse: period<=counter, period_valid<=1, counter<=1. Edges at cycles t0 and t1 give period = t1-t0. Result visible the cycle after the edge_pulse cycle.
- Timeout: in MEASURE, counter==TIMEOUT with no edge_pulse that cycle -> LOST, lost<=1, locked<=0, lock count<=0. edge_pulse in the same cycle wins: capture normally, no timeout.
- LOST: counter held. edge_pulse -> MEASURE, counter<=1, no capture (gap period discarded).
- enable=0 in any state -> IDLE next cycle: counter<=0, locked<=0, lock count<=0. A pending period/period_valid is retained until consumed. Sticky flags are unaffected.
- Lock: each capture increments lock count, saturating at LOCK_N. locked=1 when lock count==LOCK_N. Cleared only by timeout, disable or reset.
- Handshake: period and period_valid are stable until the cycle with period_valid&period_ready. That cycle clears period_valid unless a new capture coincides.
- Capture with period_valid=1 and period_ready=0: period overwritten with the new value, period_valid stays 1, overrun<=1.
- Capture coinciding with period_valid&period_ready: new value loaded, period_valid stays 1, no overrun.
- Sticky flags: clear_status clears overrun and lost. A set event in the same cycle as clear_status wins; the flag stays 1.
- No wrap: counter never exceeds TIMEOUT, because MEASURE exits at TIMEOUT.

Test Plan:
- Reset with enable=0 and random edge_pulse -> all outputs 0, state=0. enable=1 -> state=1 after 1 cycle.
- Edges 1000 cycles apart, period_ready=1 -> period=1000, period_valid high exactly 1 cycle after each second-and-later edge. locked=1 after 2nd capture (LOCK_N=2).
- period_ready=0, three edges 500 apart -> first period=500 valid. Second capture overwrites with 500 and sets overrun=1. Raise ready -> valid drops next cycle.
- TIMEOUT=50, edge then no edge -> state=3, lost=1, locked=0 at counter 50. Edge at 50 exactly -> capture 50, no loss. After LOST, next edge gives no capture; following edge 200 later -> period=200.
- enable drops mid-MEASURE with pending unread result -> state=0, locked=0, period_valid/period retained until ready pulse.
- clear_status in the same cycle as an overrun-setting capture -> overrun stays 1. clear_status alone next cycle -> overrun=0, lost=0.
